// File: rtl/lbp_window_generator.sv
// -----------------------------------------------------------------------------
// lbp_window_generator
//
// Streaming front end for the circular-LBP datapath. Accepts 8-bit greyscale
// pixels in raster order, keeps the four previous image lines in line
// buffers, and maintains a 5x5 sliding window. For every interior pixel it
// presents the radius-2 circular neighbourhood: centre, four axial samples
// and the four pixels around each diagonal sample point.
//
// Window W[r][c]: r = 0 is the oldest (top) line, c = 0 the oldest (left)
// column, centre at W[2][2]. Diagonal taps: _1 inner, _2 horizontal outer,
// _3 vertical outer, _4 corner.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   done_i         pixel valid; pixel_i is accepted in any cycle it is high
//   pixel_i[7:0]   raster-order pixel
//   mid_o          W[2][2]
//   S_0_o          W[2][4]     S_90_o   W[0][2]
//   S_180_o        W[2][0]     S_270_o  W[4][2]
//   S_45_o_1..4    W[1][3] W[1][4] W[0][3] W[0][4]
//   S_135_o_1..4   W[1][1] W[1][0] W[0][1] W[0][0]
//   S_225_o_1..4   W[3][1] W[3][0] W[4][1] W[4][0]
//   S_315_o_1..4   W[3][3] W[3][4] W[4][3] W[4][4]
//   done_o         one-cycle window-valid pulse, one cycle after the
//                  completing pixel
//   frame_done_o   pulses with the last window of a frame
// -----------------------------------------------------------------------------
module lbp_window_generator #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] pixel_i,
  output logic [7:0] mid_o,
  output logic [7:0] S_0_o,
  output logic [7:0] S_90_o,
  output logic [7:0] S_180_o,
  output logic [7:0] S_270_o,
  output logic [7:0] S_45_o_1,
  output logic [7:0] S_45_o_2,
  output logic [7:0] S_45_o_3,
  output logic [7:0] S_45_o_4,
  output logic [7:0] S_135_o_1,
  output logic [7:0] S_135_o_2,
  output logic [7:0] S_135_o_3,
  output logic [7:0] S_135_o_4,
  output logic [7:0] S_225_o_1,
  output logic [7:0] S_225_o_2,
  output logic [7:0] S_225_o_3,
  output logic [7:0] S_225_o_4,
  output logic [7:0] S_315_o_1,
  output logic [7:0] S_315_o_2,
  output logic [7:0] S_315_o_3,
  output logic [7:0] S_315_o_4,
  output logic       done_o,
  output logic       frame_done_o
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_FOUR = CW'(4);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FOUR = RW'(4);

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;

  // Line buffers: lb0 holds row-1, lb3 holds row-4 at the current column.
  logic [7:0]      r_lb0 [0:IMG_WIDTH-1];
  logic [7:0]      r_lb1 [0:IMG_WIDTH-1];
  logic [7:0]      r_lb2 [0:IMG_WIDTH-1];
  logic [7:0]      r_lb3 [0:IMG_WIDTH-1];

  logic [7:0]      r_win     [0:4][0:4];
  logic [7:0]      w_win_nxt [0:4][0:4];

  logic            w_acc;
  logic            w_col_last;
  logic            w_row_last;
  logic            w_frame_end;
  logic            w_interior;
  logic            w_first;
  logic            w_emit;

  // Reset takes priority: a pixel presented together with rst is dropped.
  assign w_acc       = done_i & ~rst;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_frame_end = w_col_last & w_row_last;
  assign w_interior  = (r_row >= ROW_FOUR) && (r_col >= COL_FOUR);
  assign w_first     = (r_row == ROW_FOUR) && (r_col == COL_FOUR);

  // ---------------------------------------------------------------------------
  // FSM: FILL suppresses output until the first complete window of a frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_acc && w_first) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          // Columns 0..3 of each line only refill the window, so the
          // interior gate also prevents mixing columns across a line wrap.
          w_emit = w_interior;
          if (w_frame_end) begin
            w_state_nxt = ST_FILL;
          end
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (done_i) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window shift: columns move left, the new column comes from the line
  // buffers (oldest line on top) with the incoming pixel at the bottom.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned r = 0; r < 5; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_win_nxt[r][c] = r_win[r][c+1];
      end
    end
    w_win_nxt[0][4] = r_lb3[r_col];
    w_win_nxt[1][4] = r_lb2[r_col];
    w_win_nxt[2][4] = r_lb1[r_col];
    w_win_nxt[3][4] = r_lb0[r_col];
    w_win_nxt[4][4] = pixel_i;
  end

  // Storage is not reset; FILL gating keeps stale contents off the outputs.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= pixel_i;
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb3[r_col] <= r_lb2[r_col];
      for (int unsigned r = 0; r < 5; r++) begin
        for (int unsigned c = 0; c < 5; c++) begin
          r_win[r][c] <= w_win_nxt[r][c];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: taps are taken from the post-shift window so data and
  // done_o appear together one cycle after the completing pixel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      mid_o        <= '0;
      S_0_o        <= '0;
      S_90_o       <= '0;
      S_180_o      <= '0;
      S_270_o      <= '0;
      S_45_o_1     <= '0;
      S_45_o_2     <= '0;
      S_45_o_3     <= '0;
      S_45_o_4     <= '0;
      S_135_o_1    <= '0;
      S_135_o_2    <= '0;
      S_135_o_3    <= '0;
      S_135_o_4    <= '0;
      S_225_o_1    <= '0;
      S_225_o_2    <= '0;
      S_225_o_3    <= '0;
      S_225_o_4    <= '0;
      S_315_o_1    <= '0;
      S_315_o_2    <= '0;
      S_315_o_3    <= '0;
      S_315_o_4    <= '0;
    end else begin
      done_o       <= w_emit;
      frame_done_o <= w_emit & w_frame_end;
      if (w_emit) begin
        mid_o     <= w_win_nxt[2][2];
        S_0_o     <= w_win_nxt[2][4];
        S_90_o    <= w_win_nxt[0][2];
        S_180_o   <= w_win_nxt[2][0];
        S_270_o   <= w_win_nxt[4][2];
        S_45_o_1  <= w_win_nxt[1][3];
        S_45_o_2  <= w_win_nxt[1][4];
        S_45_o_3  <= w_win_nxt[0][3];
        S_45_o_4  <= w_win_nxt[0][4];
        S_135_o_1 <= w_win_nxt[1][1];
        S_135_o_2 <= w_win_nxt[1][0];
        S_135_o_3 <= w_win_nxt[0][1];
        S_135_o_4 <= w_win_nxt[0][0];
        S_225_o_1 <= w_win_nxt[3][1];
        S_225_o_2 <= w_win_nxt[3][0];
        S_225_o_3 <= w_win_nxt[4][1];
        S_225_o_4 <= w_win_nxt[4][0];
        S_315_o_1 <= w_win_nxt[3][3];
        S_315_o_2 <= w_win_nxt[3][4];
        S_315_o_3 <= w_win_nxt[4][3];
        S_315_o_4 <= w_win_nxt[4][4];
      end
    end
  end

endmodule

// File: tb/tb_lbp_window_generator.sv
module tb_lbp_window_generator;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NWIN = (W - 4) * (H - 4);

  logic       clk;
  logic       rst;
  logic       done_i;
  logic [7:0] pixel_i;
  logic [7:0] mid_o, S_0_o, S_90_o, S_180_o, S_270_o;
  logic [7:0] S_45_o_1, S_45_o_2, S_45_o_3, S_45_o_4;
  logic [7:0] S_135_o_1, S_135_o_2, S_135_o_3, S_135_o_4;
  logic [7:0] S_225_o_1, S_225_o_2, S_225_o_3, S_225_o_4;
  logic [7:0] S_315_o_1, S_315_o_2, S_315_o_3, S_315_o_4;
  logic       done_o;
  logic       frame_done_o;

  int errors = 0;
  int checks = 0;

  lbp_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .pixel_i(pixel_i),
    .mid_o(mid_o), .S_0_o(S_0_o), .S_90_o(S_90_o), .S_180_o(S_180_o), .S_270_o(S_270_o),
    .S_45_o_1(S_45_o_1), .S_45_o_2(S_45_o_2), .S_45_o_3(S_45_o_3), .S_45_o_4(S_45_o_4),
    .S_135_o_1(S_135_o_1), .S_135_o_2(S_135_o_2), .S_135_o_3(S_135_o_3), .S_135_o_4(S_135_o_4),
    .S_225_o_1(S_225_o_1), .S_225_o_2(S_225_o_2), .S_225_o_3(S_225_o_3), .S_225_o_4(S_225_o_4),
    .S_315_o_1(S_315_o_1), .S_315_o_2(S_315_o_2), .S_315_o_3(S_315_o_3), .S_315_o_4(S_315_o_4),
    .done_o(done_o), .frame_done_o(frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector record: completing pixel coordinate and the 21 expected taps
  // (order: mid, S0, S90, S180, S270, S45_1..4, S135_1..4, S225_1..4, S315_1..4)
  // for base value 0.
  typedef struct {
    int               in_r;
    int               in_c;
    logic [20:0][7:0] tap;
  } vec_t;

  vec_t tbl [NWIN];

  // Window position of each tap, relative to the window's top-left corner.
  int tr [21] = '{2, 2, 0, 2, 4, 1, 1, 0, 0, 1, 1, 0, 0, 3, 3, 4, 4, 3, 3, 4, 4};
  int tc [21] = '{2, 4, 2, 0, 2, 3, 4, 3, 4, 1, 0, 1, 0, 1, 0, 1, 0, 3, 4, 3, 4};
  int first_win [21] = '{18, 20, 2, 16, 34, 11, 12, 3, 4, 9, 8, 1, 0,
                         25, 24, 33, 32, 27, 28, 35, 36};

  function automatic logic [20:0][7:0] get_taps();
    logic [20:0][7:0] g;
    g[0]  = mid_o;     g[1]  = S_0_o;     g[2]  = S_90_o;    g[3]  = S_180_o;
    g[4]  = S_270_o;
    g[5]  = S_45_o_1;  g[6]  = S_45_o_2;  g[7]  = S_45_o_3;  g[8]  = S_45_o_4;
    g[9]  = S_135_o_1; g[10] = S_135_o_2; g[11] = S_135_o_3; g[12] = S_135_o_4;
    g[13] = S_225_o_1; g[14] = S_225_o_2; g[15] = S_225_o_3; g[16] = S_225_o_4;
    g[17] = S_315_o_1; g[18] = S_315_o_2; g[19] = S_315_o_3; g[20] = S_315_o_4;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    logic [20:0][7:0] g;
    g = get_taps();
    chk({tag, " done_o"}, {31'd0, done_o}, 32'd0);
    chk({tag, " frame_done_o"}, {31'd0, frame_done_o}, 32'd0);
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("%s tap%0d", tag, k), {24'd0, g[k]}, 32'd0);
    end
  endtask

  // Sends npix pixels of a frame starting at (0,0), value base + 8r + c,
  // with `gap` idle cycles after each pixel; checks every cycle.
  task automatic send(input int base, input int gap, input int npix);
    int pulses;
    int widx;
    int r;
    int c;
    logic exp_done;
    logic exp_fd;
    logic [20:0][7:0] g;
    pulses = 0;
    widx   = 0;
    for (int p = 0; p < npix; p++) begin
      r = p / W;
      c = p % W;
      done_i  = 1'b1;
      pixel_i = 8'(base + 8 * r + c);
      @(negedge clk);
      done_i = 1'b0;
      exp_done = (widx < NWIN) && (r == tbl[widx].in_r) && (c == tbl[widx].in_c);
      exp_fd   = exp_done && (widx == NWIN - 1);
      chk($sformatf("done_o px(%0d,%0d)", r, c), {31'd0, done_o}, {31'd0, exp_done});
      chk($sformatf("frame_done_o px(%0d,%0d)", r, c), {31'd0, frame_done_o}, {31'd0, exp_fd});
      if (done_o) pulses++;
      if (exp_done) begin
        g = get_taps();
        for (int k = 0; k < 21; k++) begin
          chk($sformatf("win%0d tap%0d base%0d", widx, k, base),
              {24'd0, g[k]}, {24'd0, 8'(tbl[widx].tap[k] + base)});
        end
        widx++;
      end
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk($sformatf("idle done_o px(%0d,%0d)", r, c), {31'd0, done_o}, 32'd0);
      end
    end
    if (npix == W * H) begin
      chk($sformatf("pulse count base%0d gap%0d", base, gap), pulses, NWIN);
    end
  endtask

  initial begin
    // Vector table: first window taken verbatim from hand-computed values,
    // the rest derived from the pixel pattern 8r + c.
    for (int i = 0; i < NWIN; i++) begin
      tbl[i].in_r = 4 + i / (W - 4);
      tbl[i].in_c = 4 + i % (W - 4);
      for (int k = 0; k < 21; k++) begin
        if (i == 0)
          tbl[i].tap[k] = 8'(first_win[k]);
        else
          tbl[i].tap[k] = 8'(8 * (tbl[i].in_r - 4 + tr[k]) + (tbl[i].in_c - 4 + tc[k]));
      end
    end

    rst     = 1'b1;
    done_i  = 1'b0;
    pixel_i = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Back-to-back frame, then a second frame offset by 100.
    send(0, 0, W * H);
    send(100, 0, W * H);

    // Throttled: one pixel every third cycle.
    send(0, 2, W * H);

    // Reset mid-frame after pixel 30, then a full frame.
    send(0, 0, 31);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid-frame reset");
    send(0, 0, W * H);

    // Reset together with a valid pixel: the pixel must be dropped.
    send(0, 0, 20);
    rst     = 1'b1;
    done_i  = 1'b1;
    pixel_i = 8'hAA;
    @(negedge clk);
    rst    = 1'b0;
    done_i = 1'b0;
    chk_zero("reset priority");
    send(50, 0, W * H);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
